// File: rtl/ib_mul_8x8_seq.sv
// Sequential unsigned WIDTH x WIDTH multiplier. It issues four (WIDTH/2)-bit partial
// products through one shared multiplier and uses valid/ready handshakes on both sides.
module ib_mul_8x8_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_c,
  output logic               o_busy
);
  localparam int unsigned H = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           step;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc, c_q;
  logic [H-1:0]         a_half, b_half;
  logic [WIDTH-1:0]     pp;
  logic [2*WIDTH-1:0]   pp_ext, pp_shift, acc_sum;

  // step[1] selects the upper half of a, and step[0] selects the upper half of b.
  always_comb begin
    a_half = step[1] ? a_q[WIDTH-1:H] : a_q[H-1:0];
    b_half = step[0] ? b_q[WIDTH-1:H] : b_q[H-1:0];
    pp     = {{H{1'b0}}, a_half} * {{H{1'b0}}, b_half};
    pp_ext = {{WIDTH{1'b0}}, pp};
    case (step)
      2'd0:    pp_shift = pp_ext;
      2'd3:    pp_shift = pp_ext << WIDTH;
      default: pp_shift = pp_ext << H;
    endcase
    acc_sum = acc + pp_shift;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = CALC;
      CALC:    if (step == 2'd3) state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= IDLE;
      step  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      c_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (i_valid) begin
          a_q  <= i_a;
          b_q  <= i_b;
          acc  <= '0;
          step <= '0;
        end
        CALC: begin
          acc  <= acc_sum;
          step <= step + 2'd1;
          // Load the result register on the final step so it holds until the next completion.
          if (step == 2'd3) c_q <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_busy  = (state != IDLE);
  assign o_c     = c_q;

endmodule

// File: tb/tb_ib_mul_8x8_seq.sv
// Testbench for ib_mul_8x8_seq. It runs directed vectors, hand-written handshake
// and reset sequences, and a random run checked against a queued reference.
module tb_ib_mul_8x8_seq;
  logic        clk = 1'b0;
  logic        nrst;
  logic        valid_in, ready_out, valid_out, ready_in, busy;
  logic [7:0]  a, b;
  logic [15:0] c;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    int          stall;
  } vec_t;

  vec_t vecs[6];

  ib_mul_8x8_seq #(.WIDTH(8)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_valid(valid_in), .o_ready(ready_out),
    .i_a(a), .i_b(b), .o_valid(valid_out), .i_ready(ready_in),
    .o_c(c), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // This task is called at a negedge while the DUT is idle. It ends at the negedge after completion.
  task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] exp,
                       input int stall, input string nm);
    int cyc;
    chk({nm, "_ready_pre"}, 32'(ready_out), 32'd1);
    a = va; b = vb; valid_in = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    chk({nm, "_ready_drop"}, 32'(ready_out), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    ready_in = (stall == 0);
    cyc = 0;
    while (!valid_out && cyc < 12) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom);
      cyc++;
    end
    chk({nm, "_latency"}, 32'(cyc), 32'd4);
    chk({nm, "_c"}, 32'(c), 32'(exp));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({nm, "_stall_valid"}, 32'(valid_out), 32'd1);
      chk({nm, "_stall_c"}, 32'(c), 32'(exp));
      chk({nm, "_stall_ready"}, 32'(ready_out), 32'd0);
    end
    ready_in = 1'b1;
    @(negedge clk);
    chk({nm, "_ready_back"}, 32'(ready_out), 32'd1);
    chk({nm, "_valid_clr"}, 32'(valid_out), 32'd0);
    chk({nm, "_c_hold"}, 32'(c), 32'(exp));
  endtask

  initial begin
    logic [15:0] exp_q[$];
    logic [15:0] e;
    int last_acc, cyc, accepted, done;

    vecs[0] = '{8'h0F, 8'hF0, 16'h0E10, 0};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 0};
    vecs[2] = '{8'h00, 8'hA5, 16'h0000, 0};
    vecs[3] = '{8'h80, 8'h02, 16'h0100, 0};
    vecs[4] = '{8'h01, 8'h01, 16'h0001, 0};
    vecs[5] = '{8'h12, 8'h34, 16'h03A8, 6};

    nrst = 1'b0; valid_in = 1'b0; ready_in = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 6; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall, $sformatf("vec%0d", i));

    // Back-to-back with i_valid held high and operands changing every cycle
    valid_in = 1'b1; ready_in = 1'b1;
    last_acc = -100;
    for (int t = 0; t < 60; t++) begin
      a = 8'($urandom); b = 8'($urandom);
      if (valid_out) begin
        if (exp_q.size() == 0) chk("b2b_extra", 32'd1, 32'd0);
        else begin e = exp_q.pop_front(); chk("b2b_c", 32'(c), 32'(e)); end
      end
      if (ready_out) begin
        exp_q.push_back(16'(a) * 16'(b));
        if (last_acc >= 0) chk("b2b_spacing", 32'(t - last_acc >= 5), 32'd1);
        last_acc = t;
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      if (valid_out) begin e = exp_q.pop_front(); chk("b2b_drain", 32'(c), 32'(e)); end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);
    while (!ready_out && cyc < 30) begin @(negedge clk); cyc++; end

    // Async reset during CALC step 2
    a = 8'h5A; b = 8'hA5; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_c", 32'(c), 32'd0);
    chk("arst_ready", 32'(ready_out), 32'd1);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    do_op(8'hC3, 8'h3C, 16'h2DB4, 0, "post_rst");

    // Random operands with random stalls on both sides
    accepted = 0; done = 0; cyc = 0;
    while (done < 1000 && cyc < 40000) begin
      valid_in = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = 8'($urandom);
      ready_in = ($urandom_range(0, 2) != 0);
      if (valid_in && ready_out) begin
        exp_q.push_back(16'(a) * 16'(b));
        accepted++;
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) chk("rnd_extra", 32'd1, 32'd0);
        else begin e = exp_q.pop_front(); chk("rnd_c", 32'(c), 32'(e)); end
        done++;
      end
      @(negedge clk);
      cyc++;
    end
    valid_in = 1'b0;
    chk("rnd_done", 32'(done), 32'd1000);
    chk("rnd_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ib_mul_8x8_seq.md
Name: ib_mul_8x8_seq

Overview:
Multi-cycle unsigned WIDTH x WIDTH multiplier controller built around a single (WIDTH/2) x (WIDTH/2) partial-product multiplier. It splits each operand into halves and issues the four partial products over four consecutive cycles. Each partial product is shifted and accumulated into a 2*WIDTH result. It trades throughput for area against the single-cycle 8x8 multiplier. Valid/ready handshakes on both sides let it sit between pipeline stages in the benchmark datapath.

Parameters:
- WIDTH, 8, operand width. Must be even and >= 4. Half width H = WIDTH/2.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_nrst  input  1  asynchronous active-low reset
- i_valid  input  1  request valid
- o_ready  output  1  block can accept a request
- i_a  input  WIDTH  multiplicand, unsigned
- i_b  input  WIDTH  multiplier, unsigned
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_c  output  2*WIDTH  product i_a*i_b
- o_busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock domain (i_clk). Reset is asynchronous and active-low (i_nrst).
- Reset values:
  - state = IDLE, step counter = 0
  - operand registers = 0, accumulator = 0
  - o_valid = 0, o_ready = 1, o_busy = 0, o_c = 0
- FSM states: IDLE, CALC, DONE.
- Output decode:
  - o_ready = (state == IDLE)
  - o_valid = (state == DONE)
  - o_busy = !IDLE
- IDLE:
  - On i_valid && o_ready, register i_a and i_b, clear the accumulator, set step = 0, go to CALC.
  - When i_valid = 0, nothing changes.
- CALC: one partial product per cycle, using the single H x H multiplier instance. The operand-half mux is selected by step.
  - step 0: acc += a[H-1:0] * b[H-1:0]
  - step 1: acc += (a[H-1:0] * b[WIDTH-1:H]) << H
  - step 2: acc += (a[WIDTH-1:H] * b[H-1:0]) << H
  - step 3: acc += (a[WIDTH-1:H] * b[WIDTH-1:H]) << WIDTH
  - On step 3, go to DONE.
- Width rules:
  - Partial product is 2H = WIDTH bits, zero-extended to 2*WIDTH before shifting.
  - Accumulator is 2*WIDTH bits. It cannot overflow, since the maximum is (2^WIDTH - 1)^2.
  - Step counter is 2 bits. It wraps 3 -> 0 only on the CALC -> DONE transition.
- DONE:
  - o_c = accumulator, registered. It is held stable, together with o_valid, until i_ready.
  - On i_ready, go to IDLE. o_c keeps its last value; it is not cleared.
- Latency:
  - Request accepted at edge k gives o_valid = 1 after edge k+4.
  - Minimum initiation interval is 5 cycles: 4 CALC cycles + 1 DONE cycle with i_ready = 1. IDLE is re-entered, and o_ready rises, on the following edge.
- No overlap: o_ready = 0 throughout CALC and DONE. Requests then are ignored and not queued; i_valid may stay high.
- Operand isolation: changes on i_a and i_b after acceptance do not affect the in-flight result.
- Reset mid-operation: the in-flight operation is abandoned. All registers return to their reset values immediately (asynchronous), with no output handshake.
- i_ready is ignored outside DONE.

Test Plan:
- Reset release, then i_a=0x0F, i_b=0xF0, i_valid pulse, i_ready=1:
  - o_ready drops the cycle after accept.
  - o_valid is high exactly 4 cycles after the accept edge with o_c=0x0E10.
  - o_ready returns on the next cycle.
- Corner operands, all with i_ready=1:
  - 0xFF*0xFF -> o_c=0xFE01
  - 0x00*0xA5 -> 0x0000
  - 0x80*0x02 -> 0x0100
  - 0x01*0x01 -> 0x0001
- Backpressure: 0x12*0x34 with i_ready=0 for 6 cycles after o_valid.
  - o_valid stays 1 and o_c stays 0x03A8 throughout.
  - o_ready stays 0 throughout.
  - Completion occurs on the first i_ready=1 cycle.
- Back-to-back and isolation:
  - Hold i_valid=1 continuously with operands changing every cycle.
  - Only operands present on accept edges are used.
  - Each result matches the operands captured at its own accept edge.
  - Accepts are at least 5 cycles apart.
- Async reset: assert i_nrst=0 mid-cycle during CALC step 2.
  - o_busy, o_valid and o_c go to 0 immediately.
  - After release, a new 0xC3*0x3C request gives 0x2DB4.
- Randomised: 1000 random operand pairs with random i_valid/i_ready stalls.
  - Each o_c equals the reference product.
  - No result is dropped or duplicated.
